mips_cpu_sequencer: RTL and testbench
=====================================

MIPS_CPU_SEQUENCER -- requirements
Module: mips_cpu_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: width of mem_addr.
REQ-002 Parameter MULDIV_STALL, default 1: 1 holds MFHI/MFLO in EXEC1 while muldiv_busy; 0 ignores busy.
REQ-003 Parameter MAX_WAIT, default 0: 0 waits on waitrequest indefinitely; N>0 raises bus_timeout after N consecutive wait cycles.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 opcode  in  6  IR[31:26], valid from DECODE onward.
REQ-007 fncode  in  6  IR[5:0].
REQ-008 regimm  in  5  IR[20:16].
REQ-009 mem_addr  in  ADDR_W  effective data address (ALUOut); only [1:0] used for lanes.
REQ-010 waitrequest  in  1  memory bus stall.
REQ-011 muldiv_busy  in  1  multiply/divide unit still computing.
REQ-012 pc_next_zero  in  1  next PC equals 0 (halt convention).
REQ-013 state  out  3  current state code.
REQ-014 active  out  1  high until HALT.
REQ-015 ir_write, pc_write  out  1 each  latch IR / update PC.
REQ-016 mem_read, mem_write  out  1 each  bus strobes.
REQ-017 byteenable  out  4  bus lane enables.
REQ-018 muldiv_start  out  1  one-cycle start pulse to mul/div unit.
REQ-019 misaligned  out  1  one-cycle pulse on misaligned access.
REQ-020 bus_timeout  out  1  sticky timeout flag.

Function
REQ-021 States SHALL be HALT=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4; other codes go to HALT.
REQ-022 FETCH: mem_read=1, byteenable=1111; stays while waitrequest; on !waitrequest ir_write=1, pc_write=1, next DECODE.
REQ-023 DECODE: no strobes; always next EXEC1 after one cycle.
REQ-024 Three-cycle class (R-type ALU, jumps, branches, ALU-immediate, MTHI/MTLO, MULT/DIV): EXEC1 then FETCH.
REQ-025 Four-cycle class (loads LB/LBU/LH/LHU/LW/LWL/LWR, BLTZAL, BGEZAL): EXEC1, EXEC2, then FETCH.
REQ-026 Load EXEC1: mem_read=1, byteenable=1111; stays in EXEC1 while waitrequest.
REQ-027 Store EXEC1: mem_write=1; stays while waitrequest; lanes per REQ-028.
REQ-028 Lanes (little-endian): SW=1111 when addr[1:0]=00; SH=0011 at 00, 1100 at 10; SB=0001<<addr[1:0].
REQ-029 Misaligned SW (addr[1:0]!=00) or SH (addr[0]=1): mem_write=0, byteenable=0000, misaligned pulses one cycle, next FETCH.
REQ-030 MULT/MULTU/DIV/DIVU: muldiv_start exactly one cycle on first EXEC1 cycle.
REQ-031 MFHI/MFLO with MULDIV_STALL=1: hold EXEC1 while muldiv_busy; leave on first !busy cycle.
REQ-032 Final exec cycle with pc_next_zero=1: next HALT, not FETCH.
REQ-033 HALT: all strobes 0, active=0; remains until reset.
REQ-034 Wait counter saturates at MAX_WAIT, clears on !waitrequest; bus_timeout set sets, next HALT.
REQ-035 Unknown opcode/fncode: treated as three-cycle no-op, no strobes.
REQ-036 Strobes SHALL be decoded from registered state; no combinational path waitrequest->state.

Reset
REQ-037 reset wins over all events; next cycle state=FETCH, active=1.
REQ-038 During reset all outputs 0 except state=FETCH, active=1; bus_timeout, wait counter cleared.
REQ-039 Reset mid-stall (any state, waitrequest high) aborts the access; no write is issued afterward.

Structure
REQ-040 Shared package mips_cpu_pkg holds state enum, opcode/fncode/regimm constants, instruction-class enum.
REQ-041 One sub-module mips_cpu_lane_decode: combinational opcode+addr[1:0] -> byteenable, misaligned.

Verification
REQ-042 ADDU, waitrequest=0: states 1,2,3,1; ir_write and pc_write high in FETCH cycle only.
REQ-043 LW, waitrequest high 3 cycles in EXEC1: EXEC1 held 4 cycles, then EXEC2, then FETCH.
REQ-044 SB addr=0x...03 -> byteenable=1000; SH addr=0x...02 -> 1100; SW addr=0x...01 -> misaligned=1, mem_write=0.
REQ-045 MULT then MFLO, busy 5 cycles: one muldiv_start; MFLO EXEC1 held until busy drops.
REQ-046 JR with pc_next_zero=1: HALT after EXEC1, active=0; reset asserted in HALT -> FETCH next cycle.
REQ-047 MAX_WAIT=4, waitrequest stuck in FETCH: bus_timeout=1 after 4 waits, state HALT.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and instruction decode for the multi-cycle MIPS control sequencer.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_MULDIV,
    C_MFHILO,
    C_LINK
  } iclass_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  localparam logic [4:0] RI_BLTZAL  = 5'h10;
  localparam logic [4:0] RI_BGEZAL  = 5'h11;

  // Anything not recognised falls into C_ALU: a strobe-free three-cycle instruction.
  function automatic iclass_t classify(input logic [5:0] op,
                                       input logic [5:0] fn,
                                       input logic [4:0] rt);
    iclass_t c;
    c = C_ALU;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: c = C_MULDIV;
          FN_MFHI, FN_MFLO:                   c = C_MFHILO;
          default:                            c = C_ALU;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RI_BLTZAL || rt == RI_BGEZAL) c = C_LINK;
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: c = C_LOAD;
      OP_SB, OP_SH, OP_SW:                                  c = C_STORE;
      default:                                              c = C_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_cpu_sequencer_if.sv
// Data-memory bus between the sequencer (master) and the memory system (slave).
interface mips_cpu_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              waitrequest;
  logic              mem_read;
  logic              mem_write;
  logic [3:0]        byteenable;

  modport master (
    input  mem_addr, waitrequest,
    output mem_read, mem_write, byteenable
  );

  modport slave (
    output mem_addr, waitrequest,
    input  mem_read, mem_write, byteenable
  );
endinterface

// File: rtl/mips_cpu_lane_decode.sv
// Little-endian byte-lane decode for data accesses, with misalignment detection for SH/SW.
module mips_cpu_lane_decode
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [1:0] addr_lo,
  output logic [3:0] byteenable,
  output logic       misaligned
);

  always_comb begin
    byteenable = '0;
    misaligned = 1'b0;
    case (opcode)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: byteenable = '1;
      OP_SB: byteenable = 4'b0001 << addr_lo;
      OP_SH: begin
        if (addr_lo[0]) misaligned = 1'b1;
        else            byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        if (addr_lo != 2'b00) misaligned = 1'b1;
        else                  byteenable = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC1/EXEC2 with bus stalls,
// mul/div interlock, sticky bus timeout and PC==0 halt.
module mips_cpu_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter bit          MULDIV_STALL = 1'b1,
  parameter int unsigned MAX_WAIT     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           fncode,
  input  logic [4:0]           regimm,
  input  logic                 muldiv_busy,
  input  logic                 pc_next_zero,
  mips_cpu_sequencer_if.master bus,
  output logic [2:0]           state,
  output logic                 active,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 muldiv_start,
  output logic                 misaligned,
  output logic                 bus_timeout
);

  localparam int unsigned WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  state_t         state_q, state_n, done_st;
  iclass_t        iclass;
  logic [WCW-1:0] wait_cnt;
  logic           timeout_q;
  logic           bus_wait;
  logic           timeout_hit;
  logic [3:0]     lane_be;
  logic           lane_mis;
  logic           mem_rd, mem_wr;
  logic [3:0]     be;
  logic           unused_addr_hi;

  assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:2];
  assign iclass         = classify(opcode, fncode, regimm);

  mips_cpu_lane_decode u_lane (
    .opcode     (opcode),
    .addr_lo    (bus.mem_addr[1:0]),
    .byteenable (lane_be),
    .misaligned (lane_mis)
  );

  // The Nth consecutive stalled cycle is the last one tolerated.
  assign timeout_hit = (MAX_WAIT != 0) && bus_wait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (!bus_wait)                wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_n      = state_q;
    done_st      = pc_next_zero ? S_HALT : S_FETCH;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    be           = '0;
    muldiv_start = 1'b0;
    misaligned   = 1'b0;
    bus_wait     = 1'b0;
    case (state_q)
      S_HALT: state_n = S_HALT;
      S_FETCH: begin
        mem_rd = 1'b1;
        be     = '1;
        if (bus.waitrequest) begin
          bus_wait = 1'b1;
        end else begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: state_n = S_EXEC1;
      S_EXEC1: begin
        case (iclass)
          C_LOAD: begin
            mem_rd = 1'b1;
            be     = lane_be;
            if (bus.waitrequest) bus_wait = 1'b1;
            else                 state_n  = S_EXEC2;
          end
          C_STORE: begin
            if (lane_mis) begin
              misaligned = 1'b1;
              state_n    = done_st;
            end else begin
              mem_wr = 1'b1;
              be     = lane_be;
              if (bus.waitrequest) bus_wait = 1'b1;
              else                 state_n  = done_st;
            end
          end
          C_LINK: state_n = S_EXEC2;
          C_MULDIV: begin
            muldiv_start = 1'b1;
            state_n      = done_st;
          end
          C_MFHILO: begin
            if (!(MULDIV_STALL && muldiv_busy)) state_n = done_st;
          end
          default: state_n = done_st;
        endcase
      end
      S_EXEC2: state_n = done_st;
      default: state_n = S_HALT;
    endcase
    if (timeout_hit) state_n = S_HALT;
    // Reset forces the visible outputs to the post-reset picture in the same cycle.
    if (reset) begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      be           = '0;
      muldiv_start = 1'b0;
      misaligned   = 1'b0;
    end
  end

  assign bus.mem_read   = mem_rd;
  assign bus.mem_write  = mem_wr;
  assign bus.byteenable = be;
  assign state          = reset ? S_FETCH : state_q;
  assign active         = reset || (state_q != S_HALT);
  assign bus_timeout    = timeout_q && !reset;

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Directed checks of mips_cpu_sequencer; a second instance with MAX_WAIT=4 covers the bus timeout.
module tb_mips_cpu_sequencer;
  import mips_cpu_pkg::*;

  logic       clk;
  logic       reset, reset2;
  logic [5:0] opcode, fncode;
  logic [4:0] regimm;
  logic       muldiv_busy, pc_next_zero;
  logic [2:0] state, state2;
  logic       active, ir_write, pc_write, muldiv_start, misaligned, bus_timeout;
  logic       active2, ir_write2, pc_write2, muldiv_start2, misaligned2, bus_timeout2;
  logic       done2;
  int         n_checks = 0;
  int         n_pass = 0;

  mips_cpu_sequencer_if #(.ADDR_W(32)) bus ();
  mips_cpu_sequencer_if #(.ADDR_W(32)) bus2 ();

  mips_cpu_sequencer #(.ADDR_W(32), .MULDIV_STALL(1'b1), .MAX_WAIT(0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .fncode(fncode), .regimm(regimm),
    .muldiv_busy(muldiv_busy), .pc_next_zero(pc_next_zero), .bus(bus),
    .state(state), .active(active), .ir_write(ir_write), .pc_write(pc_write),
    .muldiv_start(muldiv_start), .misaligned(misaligned), .bus_timeout(bus_timeout)
  );

  mips_cpu_sequencer #(.ADDR_W(32), .MULDIV_STALL(1'b1), .MAX_WAIT(4)) dut2 (
    .clk(clk), .reset(reset2), .opcode(opcode), .fncode(fncode), .regimm(regimm),
    .muldiv_busy(muldiv_busy), .pc_next_zero(pc_next_zero), .bus(bus2),
    .state(state2), .active(active2), .ir_write(ir_write2), .pc_write(pc_write2),
    .muldiv_start(muldiv_start2), .misaligned(misaligned2), .bus_timeout(bus_timeout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {active, ir_write, pc_write, mem_read, mem_write, byteenable[3:0], muldiv_start, misaligned}
  localparam logic [10:0] O_F   = 11'b1_1110111100;
  localparam logic [10:0] O_RD  = 11'b1_0010111100;
  localparam logic [10:0] O_Z   = 11'b1_0000000000;
  localparam logic [10:0] O_MS  = 11'b1_0000000010;
  localparam logic [10:0] O_MIS = 11'b1_0000000001;
  localparam logic [10:0] O_H   = 11'b0_0000000000;

  function automatic logic [10:0] o_st(input logic [3:0] lanes);
    return {1'b1, 3'b000, 1'b1, lanes, 2'b00};
  endfunction

  function automatic logic [10:0] outs();
    return {active, ir_write, pc_write, bus.mem_read, bus.mem_write, bus.byteenable,
            muldiv_start, misaligned};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs were applied at posedge+1; sample at posedge+2, then advance one cycle.
  task automatic step(input string tag, input logic [2:0] st, input logic [10:0] o);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".outs"}, 32'(outs()), 32'(o));
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                       input logic [31:0] addr);
    opcode        = op;
    fncode        = fn;
    regimm        = rt;
    bus.mem_addr  = addr;
    bus.waitrequest = 1'b0;
  endtask

  task automatic fetch_decode(input string tag);
    step({tag, ".F"}, 3'd1, O_F);
    step({tag, ".D"}, 3'd2, O_Z);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // MAX_WAIT=4 instance with waitrequest stuck high in FETCH
  initial begin
    done2            = 1'b0;
    reset2           = 1'b1;
    bus2.mem_addr    = '0;
    bus2.waitrequest = 1'b1;
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("to.wait_state", 32'(state2), 32'd1);
      check("to.wait_flag", 32'(bus_timeout2), 32'd0);
      check("to.wait_rd", 32'(bus2.mem_read), 32'd1);
      @(posedge clk);
      #1;
    end
    #1;
    check("to.halt_state", 32'(state2), 32'd0);
    check("to.flag", 32'(bus_timeout2), 32'd1);
    check("to.active", 32'(active2), 32'd0);
    @(posedge clk);
    #1;
    check("to.sticky", 32'(bus_timeout2), 32'd1);
    check("to.halt_rd", 32'(bus2.mem_read), 32'd0);
    reset2 = 1'b1;
    #1;
    check("to.rst_flag", 32'(bus_timeout2), 32'd0);
    check("to.rst_state", 32'(state2), 32'd1);
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    done2  = 1'b1;
  end

  initial begin
    reset        = 1'b1;
    muldiv_busy  = 1'b0;
    pc_next_zero = 1'b0;
    instr(OP_SPECIAL, 6'h21, 5'd0, 32'h0);
    #2;
    check("rst.state", 32'(state), 32'd1);
    check("rst.outs", 32'(outs()), 32'(O_Z));
    check("rst.timeout", 32'(bus_timeout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADDU
    fetch_decode("addu");
    step("addu.E1", 3'd3, O_Z);

    // LW with three stalled EXEC1 cycles
    instr(OP_LW, 6'h0, 5'd0, 32'h1000_0000);
    fetch_decode("lw");
    bus.waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) step("lw.E1wait", 3'd3, O_RD);
    bus.waitrequest = 1'b0;
    step("lw.E1", 3'd3, O_RD);
    step("lw.E2", 3'd4, O_Z);

    // Store lanes
    instr(OP_SB, 6'h0, 5'd0, 32'h1234_5603);
    fetch_decode("sb3");
    step("sb3.E1", 3'd3, o_st(4'b1000));
    instr(OP_SB, 6'h0, 5'd0, 32'h1234_5601);
    fetch_decode("sb1");
    step("sb1.E1", 3'd3, o_st(4'b0010));
    instr(OP_SH, 6'h0, 5'd0, 32'h1234_5602);
    fetch_decode("sh2");
    step("sh2.E1", 3'd3, o_st(4'b1100));
    instr(OP_SH, 6'h0, 5'd0, 32'h1234_5600);
    fetch_decode("sh0");
    step("sh0.E1", 3'd3, o_st(4'b0011));
    instr(OP_SH, 6'h0, 5'd0, 32'h1234_5603);
    fetch_decode("sh3");
    step("sh3.E1", 3'd3, O_MIS);
    instr(OP_SW, 6'h0, 5'd0, 32'h1234_5601);
    fetch_decode("sw1");
    step("sw1.E1", 3'd3, O_MIS);

    // SW aligned with one stall cycle
    instr(OP_SW, 6'h0, 5'd0, 32'h1234_5600);
    fetch_decode("sw0");
    bus.waitrequest = 1'b1;
    step("sw0.E1wait", 3'd3, o_st(4'b1111));
    bus.waitrequest = 1'b0;
    step("sw0.E1", 3'd3, o_st(4'b1111));

    // MULT then MFLO with busy high for 5 cycles
    instr(OP_SPECIAL, FN_MULT, 5'd0, 32'h0);
    fetch_decode("mult");
    step("mult.E1", 3'd3, O_MS);
    instr(OP_SPECIAL, FN_MFLO, 5'd0, 32'h0);
    muldiv_busy = 1'b1;
    fetch_decode("mflo");
    for (int k = 0; k < 3; k++) step("mflo.E1busy", 3'd3, O_Z);
    muldiv_busy = 1'b0;
    step("mflo.E1", 3'd3, O_Z);

    // BLTZAL takes EXEC2
    instr(OP_REGIMM, 6'h0, RI_BLTZAL, 32'h0);
    fetch_decode("bltzal");
    step("bltzal.E1", 3'd3, O_Z);
    step("bltzal.E2", 3'd4, O_Z);

    // Unknown opcode is a strobe-free three-cycle instruction
    instr(6'h3f, 6'h3f, 5'd0, 32'h0);
    fetch_decode("unk");
    step("unk.E1", 3'd3, O_Z);

    // Reset during a stalled store aborts it
    instr(OP_SW, 6'h0, 5'd0, 32'h0000_0010);
    fetch_decode("swrst");
    bus.waitrequest = 1'b1;
    step("swrst.E1wait", 3'd3, o_st(4'b1111));
    reset = 1'b1;
    step("swrst.reset", 3'd1, O_Z);
    reset = 1'b0;
    instr(OP_SPECIAL, 6'h21, 5'd0, 32'h0);
    step("swrst.after", 3'd1, O_F);
    step("swrst.D", 3'd2, O_Z);
    step("swrst.E1", 3'd3, O_Z);

    // JR with next PC zero halts
    instr(OP_SPECIAL, 6'h08, 5'd0, 32'h0);
    fetch_decode("jr");
    pc_next_zero = 1'b1;
    step("jr.E1", 3'd3, O_Z);
    step("jr.halt", 3'd0, O_H);
    step("jr.halt2", 3'd0, O_H);
    reset = 1'b1;
    step("jr.reset", 3'd1, O_Z);
    reset        = 1'b0;
    pc_next_zero = 1'b0;
    step("jr.refetch", 3'd1, O_F);

    check("to.done", 32'(done2), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
